// File: rtl/data_mem_unit.sv
// Data memory stage: byte/half/word loads and stores with little-endian lanes,
// registered extended load result and misalignment suppression.
module data_mem_unit #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        MisalignErr
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;
    logic [31:0]   wlane;
    logic [3:0]    be;
    logic          misalign;
    logic          unused_addr_hi;

    // Upper address bits are dropped so accesses wrap modulo the array size.
    assign idx            = Address[AW+1:2];
    assign lane           = Address[1:0];
    assign unused_addr_hi = ^Address[31:AW+2];
    assign rd_word        = mem[idx];
    assign shifted        = rd_word >> {lane, 3'b000};

    always_comb begin
        misalign = 1'b0;
        load_ext = rd_word;
        wlane    = WriteData;
        be       = 4'b1111;
        case (MemSize)
            2'b00: begin
                load_ext = MemSigned ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'h0, shifted[7:0]};
                wlane    = {4{WriteData[7:0]}};
                be       = 4'(4'b0001 << lane);
            end
            2'b01: begin
                misalign = lane[0];
                load_ext = MemSigned ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'h0, shifted[15:0]};
                wlane    = {2{WriteData[15:0]}};
                be       = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                misalign = |lane;
            end
        endcase
    end

    // Array has no reset; a store sampled while reset is asserted is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && MemWrite && !misalign) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadData    <= 32'h0;
            ReadValid   <= 1'b0;
            MisalignErr <= 1'b0;
        end else begin
            ReadValid   <= MemRead && !misalign;
            MisalignErr <= (MemRead || MemWrite) && misalign;
            if (MemRead && !misalign) begin
                ReadData <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed vector table, async-reset sequence and
// random traffic checked against a byte-array reference model.
module tb_data_mem_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite, MemSigned;
    logic [1:0]  MemSize;
    logic [31:0] Address, WriteData;
    logic [31:0] ReadData;
    logic        ReadValid, MisalignErr;

    int total = 0;
    int bad   = 0;

    data_mem_unit #(.DEPTH_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemSigned(MemSigned), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData), .ReadValid(ReadValid),
        .MisalignErr(MisalignErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] e_rd;
        logic        e_rv;
        logic        e_me;
    } vec_t;

    // Reference model: 1 KiB byte array plus the expected output registers.
    logic [7:0]  mm [1024];
    logic [31:0] m_rd;
    logic        m_rv, m_me;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input vec_t v);
        int b, n;
        logic mis;
        logic [31:0] val;
        b   = int'(v.addr % 1024);
        n   = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        mis = (b % n) != 0;
        val = 32'h0;
        for (int i = 0; i < n; i++) val = val + (32'(mm[b+i]) << (8*i));
        if (v.sgn && n < 4 && val[8*n-1]) val = val - (32'd1 << (8*n));
        m_rv = v.rd && !mis;
        m_me = (v.rd || v.wr) && mis;
        if (m_rv) m_rd = val;
        if (v.wr && !mis)
            for (int i = 0; i < n; i++) mm[b+i] = 8'(v.wdata >> (8*i));
    endtask

    // Drive one request on the falling edge and sample just after the rising edge.
    task automatic step(input vec_t v);
        @(negedge clk);
        MemRead = v.rd; MemWrite = v.wr; MemSize = v.size;
        MemSigned = v.sgn; Address = v.addr; WriteData = v.wdata;
        model(v);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] e_rd, input logic e_rv, input logic e_me);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.e_rd = e_rd; v.e_rv = e_rv; v.e_me = e_me;
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        vec_t v;
        logic [31:0] r, addr;
        for (int i = 0; i < 1024; i++) mm[i] = 8'h0;
        m_rd = 32'h0; m_rv = 1'b0; m_me = 1'b0;

        //            rd wr sz sg addr        wdata         e_rd          rv me
        tbl.push_back(mk(0, 1, 2, 0, 32'h10,  32'hDEADBEEF, 32'h00000000, 0, 0));
        tbl.push_back(mk(1, 0, 2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 32'h11,  32'h0,        32'hFFFFFFBE, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h11,  32'h0,        32'h000000BE, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 32'h12,  32'h0,        32'hFFFFDEAD, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h13,  32'hAABBCC55, 32'hFFFFDEAD, 0, 0));
        tbl.push_back(mk(1, 0, 2, 0, 32'h10,  32'h0,        32'h55ADBEEF, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h10,  32'hFFFF1234, 32'h55ADBEEF, 0, 0));
        tbl.push_back(mk(1, 0, 2, 0, 32'h10,  32'h0,        32'h55AD1234, 1, 0));
        tbl.push_back(mk(0, 1, 2, 0, 32'h20,  32'hCAFEF00D, 32'h55AD1234, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 32'h22,  32'h99999999, 32'h55AD1234, 0, 1));
        tbl.push_back(mk(1, 0, 2, 0, 32'h20,  32'h0,        32'hCAFEF00D, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 32'h21,  32'h0,        32'hCAFEF00D, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 32'h21,  32'h0,        32'hFFFFFFF0, 1, 0));
        tbl.push_back(mk(0, 1, 2, 0, 32'h40,  32'hAAAAAAAA, 32'hFFFFFFF0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 0, 32'h40,  32'h11111111, 32'hAAAAAAAA, 1, 0));
        tbl.push_back(mk(1, 0, 2, 0, 32'h40,  32'h0,        32'h11111111, 1, 0));
        tbl.push_back(mk(0, 1, 2, 0, 32'h400, 32'h0BADF00D, 32'h11111111, 0, 0));
        tbl.push_back(mk(1, 0, 2, 0, 32'h000, 32'h0,        32'h0BADF00D, 1, 0));
        tbl.push_back(mk(0, 0, 2, 0, 32'h000, 32'h0,        32'h0BADF00D, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 32'h402, 32'h0,        32'h00000BAD, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 32'h3,   32'h0,        32'h0000000B, 1, 0));
        tbl.push_back(mk(1, 1, 2, 0, 32'h41,  32'h22222222, 32'h0000000B, 0, 1));
        tbl.push_back(mk(1, 0, 2, 0, 32'h40,  32'h0,        32'h11111111, 1, 0));

        rst_n = 1'b0;
        MemRead = 0; MemWrite = 0; MemSize = 0; MemSigned = 0;
        Address = 0; WriteData = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ReadData", ReadData, 32'h0);
        check("reset ReadValid", 32'(ReadValid), 32'h0);
        check("reset MisalignErr", 32'(MisalignErr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i]);
            check($sformatf("vec%0d ReadData", i), ReadData, tbl[i].e_rd);
            check($sformatf("vec%0d ReadValid", i), 32'(ReadValid), 32'(tbl[i].e_rv));
            check($sformatf("vec%0d MisalignErr", i), 32'(MisalignErr), 32'(tbl[i].e_me));
        end

        // Async reset between edges while a load result is being presented.
        step(mk(0, 1, 2, 0, 32'h80, 32'hDEADBEEF, 0, 0, 0));
        step(mk(1, 0, 2, 0, 32'h80, 32'h0, 0, 0, 0));
        check("pre-reset ReadData", ReadData, 32'hDEADBEEF);
        check("pre-reset ReadValid", 32'(ReadValid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async ReadData", ReadData, 32'h0);
        check("async ReadValid", 32'(ReadValid), 32'h0);
        // A store captured while reset is held must be dropped.
        @(negedge clk);
        MemRead = 0; MemWrite = 1; MemSize = 2; Address = 32'h80; WriteData = 32'h12345678;
        @(posedge clk);
        #1;
        check("in-reset ReadValid", 32'(ReadValid), 32'h0);
        @(negedge clk);
        MemWrite = 0;
        rst_n = 1'b1;
        m_rd = 32'h0; m_rv = 1'b0; m_me = 1'b0;
        step(mk(1, 0, 2, 0, 32'h80, 32'h0, 0, 0, 0));
        check("post-reset load", ReadData, 32'hDEADBEEF);
        check("post-reset ReadValid", 32'(ReadValid), 32'h1);

        // Random traffic over a pre-filled region, upper address bits randomized.
        for (int w = 0; w < 32; w++) begin
            step(mk(0, 1, 2, 0, 32'(w * 4), $urandom, 0, 0, 0));
            check("prefill ReadValid", 32'(ReadValid), 32'(m_rv));
        end
        for (int i = 0; i < 400; i++) begin
            r    = $urandom;
            addr = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 31) * 4) | 32'(r[1:0]);
            v    = mk(r[2], r[3], r[5:4], r[6], addr, $urandom, 0, 0, 0);
            step(v);
            check("rand ReadData", ReadData, m_rd);
            check("rand ReadValid", 32'(ReadValid), 32'(m_rv));
            check("rand MisalignErr", 32'(MisalignErr), 32'(m_me));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
